// File: rtl/rip_load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// rip_load_store_unit_pkg
// Shared constants and types for the rip memory stage.
//   B_WIDTH / W_WIDTH : byte and word widths
//   lsu_state_e       : load/store unit FSM states
//   F3_*              : RV32 load/store funct3 size encodings
//   lsu_misaligned()  : alignment check for a funct3 / address-low-bits pair
// -----------------------------------------------------------------------------
package rip_load_store_unit_pkg;

    localparam int B_WIDTH = 8;
    localparam int W_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        EXC  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Reserved encodings (011, 110, 111) are reported as misaligned so they
    // never reach memory.
    function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rip_load_store_unit_if.sv
// -----------------------------------------------------------------------------
// Interfaces of the load/store unit.
//
// rip_lsu_req_if : upstream issue + result bus.
//   Handshake: a request is taken at the rising edge where req_valid=1 and
//   lsu_busy=0. While lsu_busy=1 the request is ignored and upstream holds it.
//   done is a one-cycle pulse per transaction; load_we / misalign qualify it.
//   master = pipeline (drives req_*), slave = load/store unit.
//
// rip_lsu_mem_if : data port of rip_memory_management_unit.
//   Handshake: a request (mem_re or any mem_we bit) is held stable while
//   mem_busy=1 and is accepted at the rising edge where mem_busy=0.
//   mem_dout is valid the cycle after acceptance.
//   master = load/store unit, slave = MMU.
// -----------------------------------------------------------------------------
interface rip_lsu_req_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;
    logic                  lsu_busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] load_data;
    logic [4:0]            load_rd;
    logic                  load_we;
    logic                  misalign;
    logic [ADDR_WIDTH-1:0] bad_addr;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  lsu_busy, done, load_data, load_rd, load_we, misalign, bad_addr
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output lsu_busy, done, load_data, load_rd, load_we, misalign, bad_addr
    );
endinterface

interface rip_lsu_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  mem_busy;

    modport master (
        output mem_we, mem_re, mem_addr, mem_din,
        input  mem_dout, mem_busy
    );

    modport slave (
        input  mem_we, mem_re, mem_addr, mem_din,
        output mem_dout, mem_busy
    );
endinterface

// File: rtl/rip_load_store_unit_align.sv
// -----------------------------------------------------------------------------
// rip_lsu_align
// Purely combinational lane logic for the load/store unit.
//   Request side (issue-time values):
//     i_req_funct3, i_req_off, i_req_wdata -> o_req_strobe, o_req_wdata,
//                                             o_req_misalign
//   Load side (latched values + memory read word):
//     i_ld_funct3, i_ld_off, i_ld_rdata    -> o_ld_data
// -----------------------------------------------------------------------------
module rip_lsu_align
    import rip_load_store_unit_pkg::*;
(
    input  logic [2:0]         i_req_funct3,
    input  logic [1:0]         i_req_off,
    input  logic [W_WIDTH-1:0] i_req_wdata,
    output logic [3:0]         o_req_strobe,
    output logic [W_WIDTH-1:0] o_req_wdata,
    output logic               o_req_misalign,
    input  logic [2:0]         i_ld_funct3,
    input  logic [1:0]         i_ld_off,
    input  logic [W_WIDTH-1:0] i_ld_rdata,
    output logic [W_WIDTH-1:0] o_ld_data
);

    logic [W_WIDTH-1:0] w_ld_shift;

    assign o_req_misalign = lsu_misaligned(i_req_funct3, i_req_off);

    // Data is moved into the addressed lane; bytes outside the strobes are
    // don't-care for the MMU.
    assign o_req_wdata = i_req_wdata << {i_req_off, 3'b000};

    // Bits [1:0] select the size; BU/HU stores do not exist, so they fall
    // into the B/H patterns harmlessly (they are never issued as stores).
    always_comb begin
        o_req_strobe = 4'b1111;
        case (i_req_funct3[1:0])
            2'b00:   o_req_strobe = 4'b0001 << i_req_off;
            2'b01:   o_req_strobe = 4'b0011 << i_req_off;
            default: o_req_strobe = 4'b1111;
        endcase
    end

    assign w_ld_shift = i_ld_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{(W_WIDTH-8){w_ld_shift[7]}}, w_ld_shift[7:0]};
            F3_BU:   o_ld_data = {{(W_WIDTH-8){1'b0}}, w_ld_shift[7:0]};
            F3_H:    o_ld_data = {{(W_WIDTH-16){w_ld_shift[15]}}, w_ld_shift[15:0]};
            F3_HU:   o_ld_data = {{(W_WIDTH-16){1'b0}}, w_ld_shift[15:0]};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/rip_load_store_unit.sv
// -----------------------------------------------------------------------------
// rip_load_store_unit
// Memory stage of the rip core: one decoded load/store per transaction,
// driving the data port of rip_memory_management_unit.
//   clk, rstn   : clock, asynchronous active-low reset
//   req_if      : issue request in, load result / exception / done out
//   mem_if      : MMU data port (strobes, read, word address, data, busy)
//   o_dbg_state : current FSM state
// Misaligned or reserved-size accesses are reported without touching memory.
// -----------------------------------------------------------------------------
module rip_load_store_unit
    import rip_load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rstn,
    rip_lsu_req_if.slave  req_if,
    rip_lsu_mem_if.master mem_if,
    output lsu_state_e    o_dbg_state
);

    lsu_state_e            r_state,     w_state_nxt;
    logic                  r_store,     w_store_nxt;
    logic [2:0]            r_funct3,    w_funct3_nxt;
    logic [1:0]            r_off,       w_off_nxt;
    logic [4:0]            r_rd,        w_rd_nxt;
    logic [3:0]            r_mem_we,    w_mem_we_nxt;
    logic                  r_mem_re,    w_mem_re_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_din,   w_mem_din_nxt;
    logic                  r_done,      w_done_nxt;
    logic                  r_load_we,   w_load_we_nxt;
    logic                  r_misalign,  w_misalign_nxt;
    logic [DATA_WIDTH-1:0] r_load_data, w_load_data_nxt;
    logic [4:0]            r_load_rd,   w_load_rd_nxt;
    logic [ADDR_WIDTH-1:0] r_bad_addr,  w_bad_addr_nxt;

    logic [3:0]            w_req_strobe;
    logic [DATA_WIDTH-1:0] w_req_wdata;
    logic                  w_req_misalign;
    logic [DATA_WIDTH-1:0] w_ld_data;

    rip_lsu_align u_align (
        .i_req_funct3   (req_if.req_funct3),
        .i_req_off      (req_if.req_addr[1:0]),
        .i_req_wdata    (req_if.req_wdata),
        .o_req_strobe   (w_req_strobe),
        .o_req_wdata    (w_req_wdata),
        .o_req_misalign (w_req_misalign),
        .i_ld_funct3    (r_funct3),
        .i_ld_off       (r_off),
        .i_ld_rdata     (mem_if.mem_dout),
        .o_ld_data      (w_ld_data)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_store_nxt     = r_store;
        w_funct3_nxt    = r_funct3;
        w_off_nxt       = r_off;
        w_rd_nxt        = r_rd;
        w_mem_we_nxt    = r_mem_we;
        w_mem_re_nxt    = r_mem_re;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_din_nxt   = r_mem_din;
        w_done_nxt      = 1'b0;
        w_load_we_nxt   = 1'b0;
        w_misalign_nxt  = 1'b0;
        w_load_data_nxt = r_load_data;
        w_load_rd_nxt   = r_load_rd;
        w_bad_addr_nxt  = r_bad_addr;

        case (r_state)
            IDLE: begin
                if (req_if.req_valid) begin
                    w_store_nxt  = req_if.req_store;
                    w_funct3_nxt = req_if.req_funct3;
                    w_off_nxt    = req_if.req_addr[1:0];
                    w_rd_nxt     = req_if.req_rd;
                    if (w_req_misalign) begin
                        // Pulse is registered here so it appears one cycle
                        // after issue, while the FSM sits in EXC.
                        w_state_nxt    = EXC;
                        w_done_nxt     = 1'b1;
                        w_misalign_nxt = 1'b1;
                        w_bad_addr_nxt = req_if.req_addr;
                    end else begin
                        w_state_nxt    = REQ;
                        w_mem_addr_nxt = {req_if.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_if.req_store) begin
                            w_mem_we_nxt  = w_req_strobe;
                            w_mem_din_nxt = w_req_wdata;
                        end else begin
                            w_mem_re_nxt  = 1'b1;
                        end
                    end
                end
            end
            REQ: begin
                // Request stays frozen while the MMU reports busy.
                if (!mem_if.mem_busy) begin
                    w_mem_we_nxt = 4'b0000;
                    w_mem_re_nxt = 1'b0;
                    if (r_store) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                w_load_data_nxt = w_ld_data;
                w_load_rd_nxt   = r_rd;
                w_done_nxt      = 1'b1;
                w_load_we_nxt   = 1'b1;
                w_state_nxt     = IDLE;
            end
            EXC: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_store     <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            r_mem_we    <= 4'b0000;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_done      <= 1'b0;
            r_load_we   <= 1'b0;
            r_misalign  <= 1'b0;
            r_load_data <= '0;
            r_load_rd   <= 5'd0;
            r_bad_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_store     <= w_store_nxt;
            r_funct3    <= w_funct3_nxt;
            r_off       <= w_off_nxt;
            r_rd        <= w_rd_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_din   <= w_mem_din_nxt;
            r_done      <= w_done_nxt;
            r_load_we   <= w_load_we_nxt;
            r_misalign  <= w_misalign_nxt;
            r_load_data <= w_load_data_nxt;
            r_load_rd   <= w_load_rd_nxt;
            r_bad_addr  <= w_bad_addr_nxt;
        end
    end

    assign req_if.lsu_busy  = (r_state != IDLE);
    assign req_if.done      = r_done;
    assign req_if.load_data = r_load_data;
    assign req_if.load_rd   = r_load_rd;
    assign req_if.load_we   = r_load_we;
    assign req_if.misalign  = r_misalign;
    assign req_if.bad_addr  = r_bad_addr;

    assign mem_if.mem_we    = r_mem_we;
    assign mem_if.mem_re    = r_mem_re;
    assign mem_if.mem_addr  = r_mem_addr;
    assign mem_if.mem_din   = r_mem_din;

    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_rip_load_store_unit.sv
module tb_rip_load_store_unit;
  import rip_load_store_unit_pkg::*;

  // expected record: {latency[3:0], misalign, load_we, data[31:0], rd[4:0]}
  localparam int W = 43;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [4:0]  rd;
    logic        mis;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 17;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int iss_q[$];
  vec_t vecs[NV];
  lsu_state_e dbg_state;

  rip_lsu_req_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) req_if();
  rip_lsu_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if();

  rip_load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_if      (req_if),
    .mem_if      (mem_if),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] dout, input logic [4:0] rd,
                              input logic mis, input logic [3:0] we, input logic [31:0] din,
                              input logic [31:0] data);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.dout = dout;
    v.rd = rd; v.mis = mis; v.we = we; v.din = din; v.data = data;
    return v;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] we);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{we[b]}};
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic mis,
                       input logic [31:0] data, input int lat);
    int guard;
    logic [3:0] lat4;
    guard = 0;
    while (req_if.lsu_busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("issue_wait_busy", {63'd0, req_if.lsu_busy}, 64'd0);
    req_if.req_store  = st;
    req_if.req_funct3 = f3;
    req_if.req_addr   = addr;
    req_if.req_wdata  = wdata;
    req_if.req_rd     = rd;
    req_if.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    lat4 = lat[3:0];
    iss_q.push_back(cyc);
    exp_q.push_back({lat4, mis, (~st & ~mis), data, rd});
    req_if.req_valid  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 30) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    iss_q.delete();
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int lat;
    v = vecs[i];
    mem_if.mem_dout = v.dout;
    mem_if.mem_busy = 1'b0;
    lat = v.mis ? 1 : (v.st ? 2 : 3);
    issue(v.st, v.f3, v.addr, v.wdata, v.rd, v.mis, v.data, lat);
    if (v.mis) begin
      check($sformatf("v%0d_mis_mem_re", i), {63'd0, mem_if.mem_re}, 64'd0);
      check($sformatf("v%0d_mis_mem_we", i), {60'd0, mem_if.mem_we}, 64'd0);
    end else begin
      check($sformatf("v%0d_mem_we", i), {60'd0, mem_if.mem_we}, {60'd0, v.we});
      check($sformatf("v%0d_mem_re", i), {63'd0, mem_if.mem_re}, {63'd0, ~v.st});
      check($sformatf("v%0d_mem_addr", i), {32'd0, mem_if.mem_addr}, {32'd0, v.addr[31:2], 2'b00});
      if (v.st)
        check($sformatf("v%0d_mem_din", i), {32'd0, mem_if.mem_din & byte_mask(v.we)}, {32'd0, v.din});
    end
    drain();
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] mon_e;
  int mon_iss;

  always @(negedge clk) begin
    if (rstn && req_if.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_iss = iss_q.pop_front();
        check("latency", cyc - mon_iss + 1, {60'd0, mon_e[42:39]});
        check("misalign", {63'd0, req_if.misalign}, {63'd0, mon_e[38]});
        check("load_we", {63'd0, req_if.load_we}, {63'd0, mon_e[37]});
        if (mon_e[38])
          check("bad_addr", {32'd0, req_if.bad_addr}, {32'd0, mon_e[36:5]});
        else if (mon_e[37]) begin
          check("load_data", {32'd0, req_if.load_data}, {32'd0, mon_e[36:5]});
          check("load_rd", {59'd0, req_if.load_rd}, {59'd0, mon_e[4:0]});
        end
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk(1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0, 5'd0,  0, 4'b1111, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(1, F3_B,  32'h103, 32'h000000AB, 32'h0, 5'd0,  0, 4'b1000, 32'hAB000000, 32'h0);
    vecs[2]  = mk(1, F3_H,  32'h0A2, 32'h00001234, 32'h0, 5'd0,  0, 4'b1100, 32'h12340000, 32'h0);
    vecs[3]  = mk(0, F3_B,  32'h302, 32'h0, 32'h80FF7F01, 5'd5,  0, 4'b0000, 32'h0, 32'hFFFFFFFF);
    vecs[4]  = mk(0, F3_BU, 32'h302, 32'h0, 32'h80FF7F01, 5'd6,  0, 4'b0000, 32'h0, 32'h000000FF);
    vecs[5]  = mk(0, F3_H,  32'h302, 32'h0, 32'h80FF7F01, 5'd7,  0, 4'b0000, 32'h0, 32'hFFFF80FF);
    vecs[6]  = mk(0, F3_HU, 32'h302, 32'h0, 32'h80FF7F01, 5'd8,  0, 4'b0000, 32'h0, 32'h000080FF);
    vecs[7]  = mk(0, F3_B,  32'h300, 32'h0, 32'h80FF7F01, 5'd9,  0, 4'b0000, 32'h0, 32'h00000001);
    vecs[8]  = mk(0, F3_W,  32'h400, 32'h0, 32'h12345678, 5'd31, 0, 4'b0000, 32'h0, 32'h12345678);
    vecs[9]  = mk(0, F3_H,  32'h201, 32'h0, 32'h0, 5'd1, 1, 4'b0000, 32'h0, 32'h00000201);
    vecs[10] = mk(0, F3_W,  32'h202, 32'h0, 32'h0, 5'd1, 1, 4'b0000, 32'h0, 32'h00000202);
    vecs[11] = mk(1, F3_W,  32'h105, 32'h0, 32'h0, 5'd0, 1, 4'b0000, 32'h0, 32'h00000105);
    vecs[12] = mk(0, 3'b011, 32'h000, 32'h0, 32'h0, 5'd2, 1, 4'b0000, 32'h0, 32'h00000000);
    vecs[13] = mk(0, F3_B,  32'h001, 32'h0, 32'h00008000, 5'd1, 0, 4'b0000, 32'h0, 32'hFFFFFF80);
    vecs[14] = mk(0, F3_HU, 32'h000, 32'h0, 32'hABCD8001, 5'd2, 0, 4'b0000, 32'h0, 32'h00008001);
    vecs[15] = mk(1, F3_B,  32'h001, 32'h00000055, 32'h0, 5'd0, 0, 4'b0010, 32'h00005500, 32'h0);
    vecs[16] = mk(0, F3_H,  32'h000, 32'h0, 32'hABCD8001, 5'd3, 0, 4'b0000, 32'h0, 32'hFFFF8001);

    req_if.req_valid  = 1'b0;
    req_if.req_store  = 1'b0;
    req_if.req_funct3 = 3'b000;
    req_if.req_addr   = 32'h0;
    req_if.req_wdata  = 32'h0;
    req_if.req_rd     = 5'd0;
    mem_if.mem_dout   = 32'h0;
    mem_if.mem_busy   = 1'b0;

    // reset state
    #1 rstn = 1'b0;
    #1;
    check("rst_busy",      {63'd0, req_if.lsu_busy}, 64'd0);
    check("rst_done",      {63'd0, req_if.done}, 64'd0);
    check("rst_load_we",   {63'd0, req_if.load_we}, 64'd0);
    check("rst_misalign",  {63'd0, req_if.misalign}, 64'd0);
    check("rst_load_data", {32'd0, req_if.load_data}, 64'd0);
    check("rst_bad_addr",  {32'd0, req_if.bad_addr}, 64'd0);
    check("rst_mem_we",    {60'd0, mem_if.mem_we}, 64'd0);
    check("rst_mem_re",    {63'd0, mem_if.mem_re}, 64'd0);
    check("rst_mem_addr",  {32'd0, mem_if.mem_addr}, 64'd0);
    check("rst_state",     {62'd0, dbg_state}, {62'd0, IDLE});
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < NV; i++) run_vec(i);

    // back-to-back: second request issues in the cycle the first completes
    mem_if.mem_dout = 32'h00000009;
    issue(1'b1, F3_W, 32'h700, 32'h11111111, 5'd0, 1'b0, 32'h0, 2);
    issue(1'b0, F3_W, 32'h704, 32'h0, 5'd4, 1'b0, 32'h00000009, 3);
    drain();

    // MMU stall: request frozen, new req_valid ignored
    mem_if.mem_dout = 32'hCAFEF00D;
    mem_if.mem_busy = 1'b1;
    issue(1'b0, F3_W, 32'h500, 32'h0, 5'd3, 1'b0, 32'hCAFEF00D, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_mem_re",   {63'd0, mem_if.mem_re}, 64'd1);
      check("stall_mem_we",   {60'd0, mem_if.mem_we}, 64'd0);
      check("stall_mem_addr", {32'd0, mem_if.mem_addr}, 64'h500);
      req_if.req_valid = 1'b1;
      req_if.req_store = 1'b1;
      req_if.req_addr  = 32'h7F0;
      req_if.req_rd    = 5'd30;
    end
    req_if.req_valid = 1'b0;
    mem_if.mem_busy  = 1'b0;
    drain();

    // asynchronous reset while the read is outstanding
    mem_if.mem_busy = 1'b1;
    issue(1'b0, F3_W, 32'h600, 32'h0, 5'd11, 1'b0, 32'h0, 3);
    check("rst_mid_pre_re", {63'd0, mem_if.mem_re}, 64'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_mem_re", {63'd0, mem_if.mem_re}, 64'd0);
    check("rst_mid_busy",   {63'd0, req_if.lsu_busy}, 64'd0);
    check("rst_mid_state",  {62'd0, dbg_state}, {62'd0, IDLE});
    exp_q.delete();
    iss_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", {63'd0, req_if.done}, 64'd0);
    end
    rstn = 1'b1;
    mem_if.mem_busy = 1'b0;
    mem_if.mem_dout = 32'h11223344;
    @(negedge clk);
    issue(1'b0, F3_W, 32'h604, 32'h0, 5'd12, 1'b0, 32'h11223344, 3);
    drain();

    // ---------------- final report ----------------
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
